hazard_ctrl_unit: RTL

Self-contained pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB). It keeps shadow scoreboard copies of the destination info held in the ID/EX, EX/MEM and MEM/WB registers. From these it generates stall, bubble, flush and forwarding selects, plus a halt-drain state machine that produces the core's hlt output. It replaces the ad-hoc hazard and forwarding wiring with one parametrised block that also covers branch-flag hazards and store-data bypass.

---
 rtl/hazard_pkg.sv | 50 +++++
 rtl/hazard_ctrl_unit_if.sv | 44 ++++
 rtl/hazard_ctrl_unit_shadow_stage.sv | 27 ++
 rtl/hazard_ctrl_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forward-select codes,
// the shadow scoreboard entry and the halt/drain state encoding.
package hazard_pkg;

    // Register addresses are held at this fixed width inside the shadows;
    // narrower architectural addresses are zero-extended on capture.
    localparam int SHADOW_AW = 8;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef logic [SHADOW_AW-1:0] raddr_t;

    // Destination and source info of one in-flight instruction.
    typedef struct packed {
        logic   valid;
        raddr_t rd;
        logic   reg_write;
        logic   mem_read;
        logic   sets_flags;
        raddr_t rs;
        logic   rs_used;
        raddr_t rt;
        logic   rt_used;
        logic   mem_write;
    } shadow_t;

    // Stage s will write register x, and x is not the hardwired zero register.
    function automatic logic reg_match(input raddr_t x, input shadow_t s, input logic zero_reg);
        return s.valid & s.reg_write & (s.rd == x) & ~(zero_reg & (x == '0));
    endfunction

    // Youngest producer wins; a load still in MEM has no data to give yet.
    function automatic logic [1:0] fwd_sel(input raddr_t src, input shadow_t mem_e,
                                           input shadow_t wb_e, input logic zero_reg);
        if (reg_match(src, mem_e, zero_reg) && !mem_e.mem_read)
            return FWD_MEM;
        else if (reg_match(src, wb_e, zero_reg))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ID-stage decode fields in, stall/flush/forward controls out.
// The ID fields are level signals sampled every clock; there is no
// valid/ready exchange beyond id_valid qualifying the ID slot, and the
// controller answers combinationally in the same cycle.
interface hazard_ctrl_unit_if #(parameter int REG_AW = 4);
    import hazard_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_sets_flags;
    logic              id_is_branch;
    logic              id_br_taken;
    logic              id_hlt;

    logic              stall_pc;
    logic              stall_ifid;
    logic              bubble_idex;
    logic              flush_ifid;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              fwd_c;
    logic              hlt;
    state_t            dbg_state;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_reg_write,
               id_mem_read, id_mem_write, id_sets_flags, id_is_branch, id_br_taken, id_hlt,
        input  stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_a, fwd_b, fwd_c, hlt, dbg_state
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_reg_write,
               id_mem_read, id_mem_write, id_sets_flags, id_is_branch, id_br_taken, id_hlt,
        output stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_a, fwd_b, fwd_c, hlt, dbg_state
    );

endinterface

// File: rtl/hazard_ctrl_unit_shadow_stage.sv
// One shadow pipeline register: takes the upstream entry when loaded,
// otherwise becomes an invalid (bubble) entry.
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    i_load,
    input  shadow_t i_entry,
    output shadow_t o_entry
);

    shadow_t r_entry;

    // Shift in the upstream entry or a bubble each clock.
    always_ff @(posedge clk) begin
        if (rst)
            r_entry <= '0;
        else if (i_load)
            r_entry <= i_entry;
        else
            r_entry <= '0;
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: shadow scoreboard of EX/MEM/WB destinations,
// load-use and flag stalls, branch flush, operand/store-data forwarding and
// the halt-drain sequencer.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 4,
    parameter int ZERO_REG     = 1,
    parameter int STORE_BYPASS = 1,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    hazard_ctrl_unit_if.slave  bus
);

    localparam int   CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic SB    = (STORE_BYPASS != 0);

    shadow_t    w_id_entry;
    shadow_t    w_ex;
    shadow_t    w_mem;
    shadow_t    w_wb;
    raddr_t     w_rs;
    raddr_t     w_rt;
    logic       w_rs_hit;
    logic       w_rt_hit;
    logic       w_rt_exempt;
    logic       w_ld_stall;
    logic       w_fl_stall;
    logic       w_hazard;
    logic       w_stall;
    logic       w_ex_load;
    logic       w_halt_go;
    logic       w_all_empty;
    logic       w_unused_wb;

    state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic       r_hold;
    logic       r_hlt;

    assign w_rs = raddr_t'(bus.id_rs[REG_AW-1:0]);
    assign w_rt = raddr_t'(bus.id_rt[REG_AW-1:0]);

    // Pack the ID-stage fields into a shadow entry.
    always_comb begin
        w_id_entry            = '0;
        w_id_entry.valid      = 1'b1;
        w_id_entry.rd         = raddr_t'(bus.id_rd[REG_AW-1:0]);
        w_id_entry.reg_write  = bus.id_reg_write;
        w_id_entry.mem_read   = bus.id_mem_read;
        w_id_entry.sets_flags = bus.id_sets_flags;
        w_id_entry.rs         = w_rs;
        w_id_entry.rs_used    = bus.id_rs_used;
        w_id_entry.rt         = w_rt;
        w_id_entry.rt_used    = bus.id_rt_used;
        w_id_entry.mem_write  = bus.id_mem_write;
    end

    // A halt produces no result, so it enters EX as a bubble; the drain
    // then only waits for real work already behind ID.
    assign w_ex_load = bus.id_valid & ~w_stall & ~bus.id_hlt;

    hazard_shadow_stage u_ex  (.clk(clk), .rst(rst), .i_load(w_ex_load), .i_entry(w_id_entry), .o_entry(w_ex));
    hazard_shadow_stage u_mem (.clk(clk), .rst(rst), .i_load(1'b1),      .i_entry(w_ex),       .o_entry(w_mem));
    hazard_shadow_stage u_wb  (.clk(clk), .rst(rst), .i_load(1'b1),      .i_entry(w_mem),      .o_entry(w_wb));

    // Load-use: a store whose only dependence is its data operand can take
    // the loaded value late through fwd_c instead of stalling.
    assign w_rs_hit    = reg_match(w_rs, w_ex, ZR) & bus.id_rs_used;
    assign w_rt_hit    = reg_match(w_rt, w_ex, ZR) & bus.id_rt_used;
    assign w_rt_exempt = SB & bus.id_mem_write & ~w_rs_hit;
    assign w_ld_stall  = w_ex.mem_read & (w_rs_hit | (w_rt_hit & ~w_rt_exempt));

    // Branches resolve in ID, so flags still being produced in EX block them.
    assign w_fl_stall  = bus.id_is_branch & w_ex.valid & w_ex.sets_flags;

    assign w_hazard    = w_ld_stall | w_fl_stall;
    assign w_stall     = w_hazard | r_hold;
    assign w_halt_go   = bus.id_valid & bus.id_hlt & ~w_hazard;
    assign w_all_empty = ~(w_ex.valid | w_mem.valid | w_wb.valid);

    assign bus.stall_pc    = w_stall;
    assign bus.stall_ifid  = w_stall;
    assign bus.bubble_idex = w_stall;
    assign bus.flush_ifid  = bus.id_valid & bus.id_br_taken & ~bus.id_hlt & ~w_stall;
    assign bus.fwd_a       = fwd_sel(w_ex.rs, w_mem, w_wb, ZR);
    assign bus.fwd_b       = fwd_sel(w_ex.rt, w_mem, w_wb, ZR);
    assign bus.fwd_c       = w_mem.mem_write & reg_match(w_mem.rt, w_wb, ZR);
    assign bus.hlt         = r_hlt;
    assign bus.dbg_state   = r_state;

    // WB only needs its destination fields; the rest rides along unused.
    assign w_unused_wb = ^{w_wb.mem_read, w_wb.sets_flags, w_wb.rs, w_wb.rs_used,
                           w_wb.rt, w_wb.rt_used, w_wb.mem_write};

    // Halt sequencer: freeze the front end, count down while the back end
    // empties, then hold hlt until reset. The counter parks at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_hold  <= 1'b0;
            r_hlt   <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_halt_go) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= CNT_W'(DRAIN_CYCLES);
                        r_hold  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if ((r_cnt == CNT_W'(1)) && w_all_empty) begin
                        r_state <= ST_HALTED;
                        r_hlt   <= 1'b1;
                    end else if (r_cnt > CNT_W'(1)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_HALTED: begin
                    r_hold <= 1'b1;
                    r_hlt  <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_hold  <= 1'b0;
                    r_hlt   <= 1'b0;
                end
            endcase
        end
    end

endmodule
